fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, meaning first fetch address and base of the instruction ROM window.
REQ-002 Parameter ROM_BYTES, default 4096, meaning size in bytes of the fetchable window [RESET_PC, RESET_PC+ROM_BYTES-1].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_addr  output  32  byte address to instruction memory, equals PC register combinationally.
REQ-006 imem_rd  input  32  instruction word returned combinationally by instruction memory for imem_addr.
REQ-007 redirect_valid  input  1  branch/jump taken from execute; replaces PC this cycle.
REQ-008 redirect_target  input  32  new PC when redirect_valid=1.
REQ-009 id_ready  input  1  decode accepts the IF/ID entry this cycle.
REQ-010 id_valid  output  1  IF/ID entry holds a valid instruction.
REQ-011 id_instr  output  32  registered instruction word.
REQ-012 id_pc  output  32  registered address of id_instr.
REQ-013 id_pc_plus4  output  32  registered id_pc+4, modulo 2^32.
REQ-014 err_code  output  2  sticky fault: 00 none, 01 misaligned redirect, 10 out-of-window PC.
REQ-015 fetch_count  output  32  number of completed handshakes (id_valid&id_ready), wraps at 2^32.

Function
REQ-016 FSM SHALL have states BOOT, RUN, HALT; BOOT after reset, BOOT->RUN unconditionally on the first clock edge, HALT exits only via rst_n.
REQ-017 In BOOT the block SHALL hold PC=RESET_PC, keep id_valid=0, capture nothing.
REQ-018 advance = (!id_valid | id_ready); in RUN with advance=1 and no redirect, IF/ID SHALL load {imem_rd, PC, PC+4}, id_valid<=1, PC<=PC+4.
REQ-019 In RUN with advance=0 and no redirect, PC and all IF/ID outputs SHALL hold unchanged (stall).
REQ-020 Redirect SHALL have priority over advance and stall: valid in-range aligned target -> PC<=redirect_target, id_valid<=0 (wrong-path word discarded), one-cycle bubble.
REQ-021 Redirect with redirect_target[1:0]!=0 SHALL leave PC unchanged, set err_code=01, id_valid<=0, enter HALT.
REQ-022 Redirect with aligned target outside the window SHALL leave PC unchanged, set err_code=10, id_valid<=0, enter HALT.
REQ-023 Sequential advance from PC=RESET_PC+ROM_BYTES-4 SHALL still deliver that last word, then set err_code=10 and enter HALT instead of fetching beyond the window.
REQ-024 In HALT: id_valid SHALL remain at its current value until handshaked once, then 0; PC frozen; no new captures; redirects ignored.
REQ-025 err_code SHALL latch the first fault only; later faults do not overwrite it.
REQ-026 fetch_count SHALL increment by 1 on each edge with id_valid=1 and id_ready=1, in any state, including the cycle a redirect kills a different entry.
REQ-027 Fetch latency: word at PC appears on id_instr one edge after PC is presented, given advance=1.

Reset
REQ-028 On rst_n=0, asynchronously: state=BOOT, PC=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, err_code=00, fetch_count=0.
REQ-029 Reset asserted mid-stall, mid-redirect or in HALT SHALL override all other activity immediately.
REQ-030 On rst_n release, first capture SHALL occur on the second rising edge (BOOT then RUN).

Verification
REQ-031 Reset release, id_ready=1, memory words W0..W3 at BFC00000.. -> id_pc BFC00000,BFC00004,BFC00008 on successive cycles after BOOT, fetch_count=3 after three handshakes.
REQ-032 Stall: id_ready=0 for 3 cycles with id_pc=BFC00004 -> id_pc/id_instr/imem_addr=BFC00008 hold; release -> id_pc=BFC00008 next edge.
REQ-033 Redirect to BFC00100 while id_ready=0 -> next edge id_valid=0, imem_addr=BFC00100; following edge id_pc=BFC00100.
REQ-034 Redirect to BFC00102 -> err_code=01, HALT, imem_addr unchanged, later redirect to BFC00000 ignored.
REQ-035 Sequential fetch reaches BFC00FFC -> word delivered with id_pc=BFC00FFC, then err_code=10, no further id_valid.
REQ-036 rst_n pulsed low mid-stream in HALT -> outputs return to REQ-028 values asynchronously; normal fetch resumes from BFC00000.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage with a single IF/ID pipeline register. It keeps the
// program counter, presents it to a combinational instruction memory, and
// captures the returned word together with its address into IF/ID. Taken
// redirects from execute replace the PC and kill the entry being fetched.
// Faults (a misaligned redirect target, or a PC that would leave the ROM window)
// stop the stage in HALT until reset.
//
// Parameters
//   RESET_PC        first fetch address and base of the ROM window
//   ROM_BYTES       size of the fetchable window [RESET_PC, RESET_PC+ROM_BYTES-1]
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   imem_addr       byte address to instruction memory (the PC register)
//   imem_rd         instruction word for imem_addr (combinational)
//   redirect_valid  taken branch/jump from execute
//   redirect_target new PC when redirect_valid is set
//   id_ready        decode accepts the IF/ID entry this cycle
//   id_valid        IF/ID entry holds a valid instruction
//   id_instr        registered instruction word
//   id_pc           registered address of id_instr
//   id_pc_plus4     registered id_pc + 4
//   err_code        sticky first fault: 00 none, 01 misaligned, 10 out of window
//   fetch_count     number of id_valid & id_ready handshakes (wraps)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter int unsigned ROM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [1:0]  err_code,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam logic [1:0]  ERR_NONE     = 2'b00;
    localparam logic [1:0]  ERR_MISALIGN = 2'b01;
    localparam logic [1:0]  ERR_RANGE    = 2'b10;
    localparam logic [31:0] WINDOW_SIZE  = ROM_BYTES;
    localparam logic [31:0] LAST_PC      = RESET_PC + WINDOW_SIZE - 32'd4;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        valid_next;
    logic [31:0] instr_next;
    logic [31:0] id_pc_next;
    logic [31:0] id_pc_plus4_next;
    logic [1:0]  err_next;

    logic        advance;
    logic        handshake;
    logic [31:0] target_offset;
    logic        target_aligned;
    logic        target_in_window;
    logic        at_last_word;

    assign imem_addr = pc;
    assign advance   = !id_valid || id_ready;
    assign handshake = id_valid && id_ready;

    // Offset form of the window test: avoids overflow of RESET_PC + ROM_BYTES
    // when the window sits at the top of the address space.
    assign target_offset    = redirect_target - RESET_PC;
    assign target_aligned   = (redirect_target[1:0] == 2'b00);
    assign target_in_window = (redirect_target >= RESET_PC) && (target_offset < WINDOW_SIZE);
    assign at_last_word     = (pc == LAST_PC);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        valid_next       = id_valid;
        instr_next       = id_instr;
        id_pc_next       = id_pc;
        id_pc_plus4_next = id_pc_plus4;
        err_next         = err_code;

        case (state)
            BOOT: begin
                state_next = RUN;
            end

            RUN: begin
                if (redirect_valid) begin
                    // Redirect wins over advance/stall; the entry is killed
                    // whether the redirect is accepted or faults.
                    valid_next = 1'b0;
                    if (!target_aligned) begin
                        state_next = HALT;
                        if (err_code == ERR_NONE) begin
                            err_next = ERR_MISALIGN;
                        end
                    end else if (!target_in_window) begin
                        state_next = HALT;
                        if (err_code == ERR_NONE) begin
                            err_next = ERR_RANGE;
                        end
                    end else begin
                        pc_next = redirect_target;
                    end
                end else if (advance) begin
                    valid_next       = 1'b1;
                    instr_next       = imem_rd;
                    id_pc_next       = pc;
                    id_pc_plus4_next = pc + 32'd4;
                    if (at_last_word) begin
                        // Deliver the last word of the window but never
                        // step the PC past it.
                        state_next = HALT;
                        if (err_code == ERR_NONE) begin
                            err_next = ERR_RANGE;
                        end
                    end else begin
                        pc_next = pc + 32'd4;
                    end
                end
            end

            HALT: begin
                // Let decode drain the held entry, then stay empty.
                if (handshake) begin
                    valid_next = 1'b0;
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // PC, IF/ID register, fault latch and handshake counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            err_code    <= ERR_NONE;
            fetch_count <= '0;
        end else begin
            pc          <= pc_next;
            id_valid    <= valid_next;
            id_instr    <= instr_next;
            id_pc       <= id_pc_next;
            id_pc_plus4 <= id_pc_plus4_next;
            err_code    <= err_next;
            if (handshake) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule
